// File: rtl/ex_stage_pkg.sv
// Shared pipeline definitions for the execute stage.
// ALU select codes, ALUOp encodings, funct codes and the EX/MEM bundle.
package ex_stage_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    typedef struct packed {
        logic        regdst;
        logic [1:0]  aluop;
        logic        alusrc;
    } ex_ctl_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] add_result;
        logic        zero;
        logic [31:0] alu_result;
        logic [31:0] rdata2;
        logic [4:0]  write_reg;
    } ex_mem_t;

endpackage

// File: rtl/ex_stage_alu_control.sv
// ALU control decoder: maps ALUOp and funct onto a 4-bit ALU select.
// Unknown funct codes and the reserved ALUOp yield the NOP select.
module alu_control
    import ex_stage_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] alu_sel
);

    always_comb begin
        alu_sel = ALU_NOP;
        case (aluop)
            ALUOP_ADD: alu_sel = ALU_ADD;
            ALUOP_SUB: alu_sel = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_sel = ALU_ADD;
                    FUNCT_SUB: alu_sel = ALU_SUB;
                    FUNCT_AND: alu_sel = ALU_AND;
                    FUNCT_OR:  alu_sel = ALU_OR;
                    FUNCT_SLT: alu_sel = ALU_SLT;
                    FUNCT_NOR: alu_sel = ALU_NOR;
                    default:   alu_sel = ALU_NOP;
                endcase
            end
            default: alu_sel = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand mux, ALU, branch-target adder, dest mux
// and the EX/MEM pipeline latch with stall, flush and async reset.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  ex_ctlwb_out,
    input  logic [2:0]  ex_ctlm_out,
    input  logic [3:0]  ex_ctlout,
    input  logic [31:0] add_in1,
    input  logic [31:0] A,
    input  logic [31:0] ex_readdat2,
    input  logic [31:0] s_extendout,
    input  logic [5:0]  funct,
    input  logic [4:0]  ex_b,
    input  logic [4:0]  ex_a,
    output logic [1:0]  mem_ctlwb_out,
    output logic [2:0]  mem_ctlm_out,
    output logic [31:0] mem_add_result,
    output logic        mem_zero,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_rdata2,
    output logic [4:0]  mem_write_reg
);

    ex_ctl_t     w_ctl;
    logic [3:0]  w_alu_sel;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_res;
    logic        w_zero;
    logic [31:0] w_br_target;
    logic [4:0]  w_wreg;
    ex_mem_t     w_next;
    ex_mem_t     r_exmem;

    assign w_ctl = ex_ctl_t'(ex_ctlout);

    alu_control u_alu_control (
        .aluop   (w_ctl.aluop),
        .funct   (funct),
        .alu_sel (w_alu_sel)
    );

    assign w_alu_b = w_ctl.alusrc ? s_extendout : ex_readdat2;

    always_comb begin
        w_alu_res = 32'd0;
        case (w_alu_sel)
            ALU_AND: w_alu_res = A & w_alu_b;
            ALU_OR:  w_alu_res = A | w_alu_b;
            ALU_ADD: w_alu_res = A + w_alu_b;
            ALU_SUB: w_alu_res = A - w_alu_b;
            ALU_SLT: w_alu_res = {31'd0, $signed(A) < $signed(w_alu_b)};
            ALU_NOR: w_alu_res = ~(A | w_alu_b);
            default: w_alu_res = 32'd0;
        endcase
    end

    assign w_zero      = (w_alu_res == 32'd0);
    assign w_br_target = add_in1 + {s_extendout[29:0], 2'b00};
    assign w_wreg      = w_ctl.regdst ? ex_a : ex_b;

    always_comb begin
        w_next.wb         = ex_ctlwb_out;
        w_next.m          = ex_ctlm_out;
        w_next.add_result = w_br_target;
        w_next.zero       = w_zero;
        w_next.alu_result = w_alu_res;
        w_next.rdata2     = ex_readdat2;
        w_next.write_reg  = w_wreg;
        if (flush) begin
            w_next.wb = 2'b00;
            w_next.m  = 3'b000;
        end
    end

    // Flush wins over stall: a bubble must never be held back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exmem <= '0;
        end else if (flush || !stall) begin
            r_exmem <= w_next;
        end
    end

    assign mem_ctlwb_out  = r_exmem.wb;
    assign mem_ctlm_out   = r_exmem.m;
    assign mem_add_result = r_exmem.add_result;
    assign mem_zero       = r_exmem.zero;
    assign mem_alu_result = r_exmem.alu_result;
    assign mem_rdata2     = r_exmem.rdata2;
    assign mem_write_reg  = r_exmem.write_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push expected
// EX/MEM contents, a monitor pops and compares after each edge.
module tb_ex_stage;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] add;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  wreg;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  ex_ctlwb_out = '0;
    logic [2:0]  ex_ctlm_out = '0;
    logic [3:0]  ex_ctlout = '0;
    logic [31:0] add_in1 = '0;
    logic [31:0] A = '0;
    logic [31:0] ex_readdat2 = '0;
    logic [31:0] s_extendout = '0;
    logic [5:0]  funct = '0;
    logic [4:0]  ex_b = '0;
    logic [4:0]  ex_a = '0;
    logic [1:0]  mem_ctlwb_out;
    logic [2:0]  mem_ctlm_out;
    logic [31:0] mem_add_result;
    logic        mem_zero;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_rdata2;
    logic [4:0]  mem_write_reg;

    exp_t q_exp[$];
    exp_t last_exp = '0;
    int   errors = 0;
    int   checks = 0;
    string q_name[$];

    ex_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .ex_ctlwb_out   (ex_ctlwb_out),
        .ex_ctlm_out    (ex_ctlm_out),
        .ex_ctlout      (ex_ctlout),
        .add_in1        (add_in1),
        .A              (A),
        .ex_readdat2    (ex_readdat2),
        .s_extendout    (s_extendout),
        .funct          (funct),
        .ex_b           (ex_b),
        .ex_a           (ex_a),
        .mem_ctlwb_out  (mem_ctlwb_out),
        .mem_ctlm_out   (mem_ctlm_out),
        .mem_add_result (mem_add_result),
        .mem_zero       (mem_zero),
        .mem_alu_result (mem_alu_result),
        .mem_rdata2     (mem_rdata2),
        .mem_write_reg  (mem_write_reg)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(
        input logic [1:0] wb, input logic [2:0] m,
        input logic [31:0] add, input logic zero,
        input logic [31:0] alu, input logic [31:0] rd2,
        input logic [4:0] wreg);
        exp_t e;
        e.wb = wb; e.m = m; e.add = add; e.zero = zero;
        e.alu = alu; e.rd2 = rd2; e.wreg = wreg;
        return e;
    endfunction

    function automatic exp_t dut_now();
        return mk(mem_ctlwb_out, mem_ctlm_out, mem_add_result,
                  mem_zero, mem_alu_result, mem_rdata2, mem_write_reg);
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t e);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got wb=%b m=%b add=%h z=%b alu=%h rd2=%h wr=%0d want wb=%b m=%b add=%h z=%b alu=%h rd2=%h wr=%0d",
                     name, got.wb, got.m, got.add, got.zero, got.alu, got.rd2,
                     got.wreg, e.wb, e.m, e.add, e.zero, e.alu, e.rd2, e.wreg);
        end
    endtask

    // Monitor: each edge that a vector was issued for gets compared.
    always @(posedge clk) begin
        #1;
        if (q_exp.size() > 0) begin
            check(q_name.pop_front(), dut_now(), q_exp.pop_front());
        end
    end

    task automatic vec(
        input string name,
        input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ctl,
        input logic [31:0] pc4, input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] imm, input logic [5:0] fn,
        input logic [4:0] rd, input logic [4:0] rt,
        input logic st, input logic fl, input exp_t e);
        @(negedge clk);
        ex_ctlwb_out = wb; ex_ctlm_out = m; ex_ctlout = ctl;
        add_in1 = pc4; A = a; ex_readdat2 = b; s_extendout = imm;
        funct = fn; ex_a = rd; ex_b = rt; stall = st; flush = fl;
        q_exp.push_back(e);
        q_name.push_back(name);
        last_exp = e;
    endtask

    initial begin
        #2;
        check("reset_t0", dut_now(), '0);
        @(posedge clk); #1;
        check("reset_edge", dut_now(), '0);
        @(negedge clk);
        reset = 1'b0;

        vec("radd", 2'b10, 3'b000, 4'b1100, 32'h4, 32'd5, 32'd7,
            32'h10, 6'b100000, 5'd3, 5'd2, 0, 0,
            mk(2'b10, 3'b000, 32'h44, 0, 32'd12, 32'd7, 5'd3));
        vec("beq", 2'b00, 3'b100, 4'b0010, 32'h100, 32'd9, 32'd9,
            32'hFFFFFFFF, 6'b111111, 5'd5, 5'd6, 0, 0,
            mk(2'b00, 3'b100, 32'hFC, 1, 32'd0, 32'd9, 5'd6));
        vec("slt_neg", 2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFFFFFF, 32'd1,
            32'h0, 6'b101010, 5'd7, 5'd1, 0, 0,
            mk(2'b10, 3'b000, 32'h0, 0, 32'd1, 32'd1, 5'd7));
        vec("slt_swap", 2'b10, 3'b000, 4'b1100, 32'h0, 32'd1, 32'hFFFFFFFF,
            32'h0, 6'b101010, 5'd7, 5'd1, 0, 0,
            mk(2'b10, 3'b000, 32'h0, 1, 32'd0, 32'hFFFFFFFF, 5'd7));
        vec("lw", 2'b11, 3'b010, 4'b0001, 32'h20, 32'h1000, 32'hDEAD,
            32'hFFFFFFFC, 6'b111100, 5'd9, 5'd8, 0, 0,
            mk(2'b11, 3'b010, 32'h10, 0, 32'hFFC, 32'hDEAD, 5'd8));
        vec("rsub", 2'b10, 3'b000, 4'b1100, 32'h0, 32'd3, 32'd5,
            32'h0, 6'b100010, 5'd4, 5'd1, 0, 0,
            mk(2'b10, 3'b000, 32'h0, 0, 32'hFFFFFFFE, 32'd5, 5'd4));
        vec("rand", 2'b10, 3'b000, 4'b1100, 32'h8, 32'hF0F000FF, 32'h0FF00F0F,
            32'h1, 6'b100100, 5'd11, 5'd1, 0, 0,
            mk(2'b10, 3'b000, 32'hC, 0, 32'h00F0000F, 32'h0FF00F0F, 5'd11));
        vec("ror", 2'b10, 3'b000, 4'b1100, 32'h8, 32'hF0F000FF, 32'h0FF00F0F,
            32'h1, 6'b100101, 5'd12, 5'd1, 0, 0,
            mk(2'b10, 3'b000, 32'hC, 0, 32'hFFF00FFF, 32'h0FF00F0F, 5'd12));
        vec("rnor", 2'b10, 3'b000, 4'b1100, 32'h8, 32'hF0F000FF, 32'h0FF00F0F,
            32'h1, 6'b100111, 5'd13, 5'd1, 0, 0,
            mk(2'b10, 3'b000, 32'hC, 0, 32'h000FF000, 32'h0FF00F0F, 5'd13));
        vec("bad_funct", 2'b10, 3'b000, 4'b1100, 32'h0, 32'd6, 32'd2,
            32'h0, 6'b000000, 5'd14, 5'd1, 0, 0,
            mk(2'b10, 3'b000, 32'h0, 1, 32'd0, 32'd2, 5'd14));
        vec("aluop11", 2'b01, 3'b001, 4'b0110, 32'h40, 32'd6, 32'd2,
            32'h4, 6'b100000, 5'd14, 5'd15, 0, 0,
            mk(2'b01, 3'b001, 32'h50, 1, 32'd0, 32'd2, 5'd15));
        vec("stall1", 2'b11, 3'b111, 4'b1100, 32'h1234, 32'd1, 32'd1,
            32'h7, 6'b100000, 5'd20, 5'd21, 1, 0, last_exp);
        vec("stall2", 2'b10, 3'b010, 4'b0001, 32'h5678, 32'd9, 32'd8,
            32'h3, 6'b100010, 5'd22, 5'd23, 1, 0, last_exp);
        vec("flush", 2'b10, 3'b010, 4'b1100, 32'h10, 32'd1, 32'd2,
            32'h1, 6'b100000, 5'd10, 5'd1, 0, 1,
            mk(2'b00, 3'b000, 32'h14, 0, 32'd3, 32'd2, 5'd10));
        vec("stall_flush", 2'b11, 3'b101, 4'b1100, 32'h0, 32'd4, 32'd4,
            32'h0, 6'b100010, 5'd17, 5'd1, 1, 1,
            mk(2'b00, 3'b000, 32'h0, 1, 32'd0, 32'd4, 5'd17));
        vec("br_wrap", 2'b00, 3'b100, 4'b0010, 32'hFFFFFFFC, 32'd1, 32'd2,
            32'h2, 6'b000010, 5'd1, 5'd2, 0, 0,
            mk(2'b00, 3'b100, 32'h4, 0, 32'hFFFFFFFF, 32'd2, 5'd2));
        vec("add_ovf", 2'b10, 3'b000, 4'b1100, 32'h0, 32'h7FFFFFFF, 32'd1,
            32'h0, 6'b100000, 5'd18, 5'd1, 0, 0,
            mk(2'b10, 3'b000, 32'h0, 0, 32'h80000000, 32'd1, 5'd18));
        vec("add_wrap0", 2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFFFFFF, 32'd1,
            32'h0, 6'b100000, 5'd19, 5'd1, 0, 0,
            mk(2'b10, 3'b000, 32'h0, 1, 32'd0, 32'd1, 5'd19));

        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("reset_midcycle", dut_now(), '0);
        @(negedge clk);
        stall = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        check("reset_held_flush", dut_now(), '0);
        @(negedge clk);
        stall = 1'b1; flush = 1'b0;
        @(posedge clk); #1;
        check("reset_held_stall", dut_now(), '0);
        @(negedge clk);
        reset = 1'b0;

        vec("post_reset", 2'b10, 3'b000, 4'b1100, 32'h4, 32'd5, 32'd7,
            32'h10, 6'b100000, 5'd3, 5'd2, 0, 0,
            mk(2'b10, 3'b000, 32'h44, 0, 32'd12, 32'd7, 5'd3));

        repeat (3) @(posedge clk);
        #2;
        if (q_exp.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, want 0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
